// File: rtl/pingpong_dbram_pkg.sv
// Shared definitions for the two-bank ping-pong buffer:
// the bank-index type and the bit positions of the sticky error flags.
package pingpong_dbram_pkg;

    typedef logic bank_t;

    localparam int unsigned NUM_BANKS = 2;
    localparam int unsigned ERR_WR    = 0;
    localparam int unsigned ERR_RD    = 1;

endpackage

// File: rtl/sdpram_bank.sv
// Simple dual-port RAM bank: one write port, one read port with a registered output.
// The output register only loads on a read, so it holds its last value otherwise.
module sdpram_bank #(
    parameter int unsigned DWIDTH    = 40,
    parameter int unsigned AWIDTH    = 11,
    parameter int unsigned NUM_WORDS = 2048
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);

`ifdef hard_mem
    // Port 1 is write-only, port 2 is read-only.
    dual_port_ram #(
        .DWIDTH    (DWIDTH),
        .AWIDTH    (AWIDTH),
        .NUM_WORDS (NUM_WORDS)
    ) u_ram (
        .clk   (clk),
        .en1   (wr_en),
        .we1   (wr_en),
        .addr1 (wr_addr),
        .data1 (wr_data),
        .out1  (),
        .en2   (rd_en),
        .we2   (1'b0),
        .addr2 (rd_addr),
        .data2 ('0),
        .out2  (rd_data)
    );
`else
    logic [DWIDTH-1:0] mem [NUM_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
`endif

endmodule

// File: rtl/pingpong_dbram.sv
// Two-bank ping-pong buffer with flow-controlled ownership: banks pass from
// producer to consumer on commit and back on release.
module pingpong_dbram
    import pingpong_dbram_pkg::*;
#(
    parameter int unsigned DWIDTH    = 40,
    parameter int unsigned AWIDTH    = 11,
    parameter int unsigned NUM_WORDS = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              wr_commit,
    output logic              wr_ready,
    output logic              wr_bank,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    input  logic              rd_release,
    output logic              rd_avail,
    output logic              rd_bank,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic [1:0]        full_count,
    output logic [1:0]        err
);

    logic [NUM_BANKS-1:0] full;
    logic [NUM_BANKS-1:0] full_next;
    bank_t                wr_ptr;
    bank_t                rd_ptr;
    bank_t                rd_sel;
    logic                 rd_seen;

    logic                 wr_ok;
    logic                 commit_ok;
    logic                 rd_ok;
    logic                 release_ok;

    logic [NUM_BANKS-1:0] bank_we;
    logic [NUM_BANKS-1:0] bank_re;
    logic [DWIDTH-1:0]    bank_q [NUM_BANKS];

    assign wr_ready   = !full[wr_ptr];
    assign rd_avail   = full[rd_ptr];
    assign wr_bank    = wr_ptr;
    assign rd_bank    = rd_ptr;
    assign full_count = {1'b0, full[0]} + {1'b0, full[1]};

    assign wr_ok      = wr_en      && wr_ready && !reset;
    assign commit_ok  = wr_commit  && wr_ready;
    assign rd_ok      = rd_en      && rd_avail && !reset;
    assign release_ok = rd_release && rd_avail;

    // Commit and release can never hit the same bank (one needs it empty, the other full).
    always_comb begin
        full_next = full;
        if (commit_ok) begin
            full_next[wr_ptr] = 1'b1;
        end
        if (release_ok) begin
            full_next[rd_ptr] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full     <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            rd_sel   <= 1'b0;
            rd_seen  <= 1'b0;
            rd_valid <= 1'b0;
            err      <= '0;
        end else begin
            full     <= full_next;
            rd_valid <= rd_ok;
            if (commit_ok) begin
                wr_ptr <= ~wr_ptr;
            end
            if (release_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            if (rd_ok) begin
                rd_sel  <= rd_ptr;
                rd_seen <= 1'b1;
            end
            if ((wr_en || wr_commit) && !wr_ready) begin
                err[ERR_WR] <= 1'b1;
            end
            if ((rd_en || rd_release) && !rd_avail) begin
                err[ERR_RD] <= 1'b1;
            end
        end
    end

    assign bank_we = {wr_ok &  wr_ptr, wr_ok & ~wr_ptr};
    assign bank_re = {rd_ok &  rd_ptr, rd_ok & ~rd_ptr};

    sdpram_bank #(
        .DWIDTH    (DWIDTH),
        .AWIDTH    (AWIDTH),
        .NUM_WORDS (NUM_WORDS)
    ) u_bank0 (
        .clk     (clk),
        .wr_en   (bank_we[0]),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (bank_re[0]),
        .rd_addr (rd_addr),
        .rd_data (bank_q[0])
    );

    sdpram_bank #(
        .DWIDTH    (DWIDTH),
        .AWIDTH    (AWIDTH),
        .NUM_WORDS (NUM_WORDS)
    ) u_bank1 (
        .clk     (clk),
        .wr_en   (bank_we[1]),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (bank_re[1]),
        .rd_addr (rd_addr),
        .rd_data (bank_q[1])
    );

    // Each bank's output register only moves on its own read, so selecting the
    // last-read bank gives hold-on-idle; rd_seen forces zero until the first read.
    assign rd_data = rd_seen ? bank_q[rd_sel] : '0;

endmodule

// File: tb/tb_pingpong_dbram.sv
// Scoreboard bench for pingpong_dbram: directed handshake scenarios then random
// traffic, checked against a commit/release counter model of bank ownership.
module tb_pingpong_dbram;

    localparam int unsigned DW = 40;
    localparam int unsigned AW = 4;
    localparam int unsigned NW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_commit;
    logic          wr_ready;
    logic          wr_bank;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_release;
    logic          rd_avail;
    logic          rd_bank;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [1:0]    full_count;
    logic [1:0]    err;

    pingpong_dbram #(
        .DWIDTH    (DW),
        .AWIDTH    (AW),
        .NUM_WORDS (NW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_commit  (wr_commit),
        .wr_ready   (wr_ready),
        .wr_bank    (wr_bank),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_release (rd_release),
        .rd_avail   (rd_avail),
        .rd_bank    (rd_bank),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .full_count (full_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: ownership as counts of commits and releases since reset.
    int            committed;
    int            consumed;
    logic [DW-1:0] mem_m   [2][NW];
    bit            written [2][NW];
    logic [1:0]    err_m;
    bit            rv_m;
    logic [DW-1:0] rdata_m;
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit we, input int wa, input logic [DW-1:0] wd, input bit wc,
                        input bit re, input int ra, input bit rr, input bit rst);
        int pend;
        int wb;
        int rb;
        bit wrdy;
        bit ravl;
        reset      = rst;
        wr_en      = we;
        wr_addr    = AW'(wa);
        wr_data    = wd;
        wr_commit  = wc;
        rd_en      = re;
        rd_addr    = AW'(ra);
        rd_release = rr;
        @(posedge clk);
        if (rst) begin
            committed = 0;
            consumed  = 0;
            err_m     = 2'b00;
            rv_m      = 1'b0;
            rdata_m   = '0;
        end else begin
            pend = committed - consumed;
            wb   = committed % 2;
            rb   = consumed % 2;
            wrdy = (pend < 2);
            ravl = (pend > 0);
            if ((we || wc) && !wrdy) err_m[0] = 1'b1;
            if ((re || rr) && !ravl) err_m[1] = 1'b1;
            if (we && wrdy) begin
                mem_m[wb][wa]   = wd;
                written[wb][wa] = 1'b1;
            end
            rv_m = re && ravl;
            if (rv_m) begin
                rdata_m = mem_m[rb][ra];
                exp_q.push_back(rdata_m);
            end
            if (wc && wrdy) committed++;
            if (rr && ravl) consumed++;
        end
        #1;
        pend = committed - consumed;
        chk("wr_ready",   wr_ready,   64'(pend < 2));
        chk("rd_avail",   rd_avail,   64'(pend > 0));
        chk("wr_bank",    wr_bank,    64'(committed % 2));
        chk("rd_bank",    rd_bank,    64'(consumed % 2));
        chk("full_count", full_count, 64'(pend));
        chk("err",        err,        64'(err_m));
        chk("rd_valid",   rd_valid,   64'(rv_m));
        chk("rd_data",    rd_data,    64'(rdata_m));
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every presented read word must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got rd_valid=1 expected no outstanding read at %0t", $time);
                end else begin
                    chk("sb_rd_data", rd_data, 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [63:0] rnd;
        int pend;
        int rb;
        int ra;
        bit we, wc, re, rr, rst;

        for (int b = 0; b < 2; b++)
            for (int a = 0; a < int'(NW); a++)
                written[b][a] = 1'b0;

        step(0, 0, '0, 0, 0, 0, 0, 1);
        idle();
        // Read with nothing available: no valid, read error flagged.
        step(0, 0, '0, 0, 1, 0, 0, 0);
        idle();
        chk("err_rd_after_reset", err, 64'h2);
        step(0, 0, '0, 0, 0, 0, 0, 1);

        // Fill bank 0, commit, read back.
        for (int i = 0; i < 4; i++) step(1, i, 40'hA0 + 40'(i), 0, 0, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 0, 0);
        chk("avail_after_commit", rd_avail, 64'h1);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 1, i, 0, 0);
        idle();

        // Fill bank 1 too: both full, further write rejected, bank 0 intact.
        for (int i = 0; i < 4; i++) step(1, i, 40'hB0 + 40'(i), 0, 0, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 0, 0);
        chk("both_full", full_count, 64'h2);
        step(1, 0, 40'hDEAD, 0, 0, 0, 0, 0);
        step(0, 0, '0, 0, 1, 0, 0, 0);
        idle();
        chk("bank0_intact", rd_data, 64'hA0);

        // Reset mid-stream with both banks full; RAM keeps its contents.
        step(0, 0, '0, 0, 0, 0, 0, 1);
        chk("reset_ready", wr_ready, 64'h1);
        step(0, 0, '0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 1, i, 0, 0);
        idle();

        // Commit bank 1 and release bank 0 together.
        step(1, 5, 40'h77, 0, 0, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 1, 0);
        chk("swap_count", full_count, 64'h1);
        chk("swap_no_err", err, 64'h0);

        // Read and release bank 0 in the same cycle.
        step(1, 5, 40'h55, 0, 0, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 0, 0);
        step(0, 0, '0, 0, 0, 0, 1, 0);
        step(0, 0, '0, 0, 1, 5, 1, 0);
        chk("rd_release_data", rd_data, 64'h55);
        chk("rd_release_bank", rd_bank, 64'h1);
        idle();

        // Random traffic, mostly legal, with occasional rejected requests and resets.
        for (int n = 0; n < 4000; n++) begin
            pend = committed - consumed;
            rb   = consumed % 2;
            rnd  = {$urandom, $urandom};
            we   = (pend < 2) ? ($urandom_range(99) < 60) : ($urandom_range(99) < 3);
            wc   = (pend < 2) ? ($urandom_range(99) < 8)  : ($urandom_range(999) < 5);
            re   = (pend > 0) ? ($urandom_range(99) < 70) : ($urandom_range(99) < 1);
            rr   = (pend > 0) ? ($urandom_range(99) < 8)  : ($urandom_range(999) < 5);
            rst  = ($urandom_range(999) < 3);
            ra   = int'($urandom_range(NW - 1));
            if (pend > 0 && !written[rb][ra]) re = 1'b0;
            step(we, int'($urandom_range(NW - 1)), rnd[DW-1:0], wc, re, ra, rr, rst);
        end

        idle();
        idle();
        chk("sb_drained", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
